// File: rtl/md_hilo_unit_if.sv
// md_hilo_unit_if: issue/result bundle between the ID/EX control path and
// the HI/LO multiply/divide unit.
//   start/op/a/b : one-cycle issue strobe, op code, rs/rt operands
//   flush        : synchronous squash of the in-flight operation
//   busy         : unit is executing a MUL/DIV
//   hi/lo        : architectural HI/LO registers
// master = issuing side, slave = md_hilo_unit.
interface md_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/md_hilo_unit.sv
// md_hilo_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : md_hilo_unit_if.slave (start/op/a/b/flush in, busy/hi/lo out)
// Multiplies hold busy for MUL_CYCLES cycles; divides use a radix-2
// restoring loop (WIDTH iterations) plus one sign-fixup cycle.
module md_hilo_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  md_hilo_unit_if.slave bus
);

  localparam int unsigned CW = $clog2((WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
    OP_MTHI = 3'd4, OP_MTLO = 3'd5
  } op_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa, r_opb;   // MUL: operands; DIV: original a, |b|
  logic             r_msigned;
  logic [WIDTH-1:0] r_q, r_rem;     // dividend/quotient shift reg, partial remainder
  logic             r_qneg, r_rneg, r_dz;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_accept, w_is_mul, w_is_div, w_sdiv;
  logic             w_mul_done, w_fix_done;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_ea, w_eb, w_prod;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff, w_q_fin, w_r_fin;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_sdiv   = (bus.op == OP_DIV);

  assign w_a_mag = (w_sdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag = (w_sdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Extending to 2*WIDTH and keeping the low half gives the correct product
  // for both signed and unsigned operands.
  assign w_ea   = {{WIDTH{r_msigned & r_opa[WIDTH-1]}}, r_opa};
  assign w_eb   = {{WIDTH{r_msigned & r_opb[WIDTH-1]}}, r_opb};
  assign w_prod = w_ea * w_eb;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_diff  = w_shift[WIDTH-1:0] - r_opb;

  assign w_q_fin = r_qneg ? -r_q   : r_q;
  assign w_r_fin = r_rneg ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_mul_done = 1'b0;
    w_fix_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL;
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_MUL: begin
        if (bus.flush) w_next = S_IDLE;
        else if (r_cnt == '0) begin
          w_next     = S_IDLE;
          w_mul_done = 1'b1;
        end
      end
      S_DIV: begin
        if (bus.flush)             w_next = S_IDLE;
        else if (r_cnt == '0)      w_next = S_FIX;
      end
      S_FIX: begin
        w_next     = S_IDLE;
        w_fix_done = !bus.flush;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_msigned <= 1'b0;
      r_q       <= '0;
      r_rem     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_accept) begin
        if (w_is_mul) begin
          r_cnt     <= CW'(MUL_CYCLES - 1);
          r_opa     <= bus.a;
          r_opb     <= bus.b;
          r_msigned <= (bus.op == OP_MULT);
        end else if (w_is_div) begin
          r_cnt  <= CW'(WIDTH - 1);
          r_opa  <= bus.a;
          r_opb  <= w_b_mag;
          r_q    <= w_a_mag;
          r_rem  <= '0;
          r_qneg <= w_sdiv && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          r_rneg <= w_sdiv && bus.a[WIDTH-1];
          r_dz   <= (bus.b == '0);
        end else if (bus.op == OP_MTHI) begin
          r_hi <= bus.a;
        end else if (bus.op == OP_MTLO) begin
          r_lo <= bus.a;
        end
      end

      if (r_state == S_MUL && r_cnt != '0) r_cnt <= r_cnt - 1'b1;

      if (r_state == S_DIV) begin
        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end

      if (w_mul_done) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end

      // Divide by zero bypasses the sign fixup: lo is all ones, hi the raw dividend.
      if (w_fix_done) begin
        r_lo <= r_dz ? '1 : w_q_fin;
        r_hi <= r_dz ? r_opa : w_r_fin;
      end
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: directed vectors, expected results
// queued at issue and checked by a monitor when busy falls.
module tb_md_hilo_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_hilo_unit_if #(.WIDTH(32)) u_if ();

  md_hilo_unit #(.WIDTH(32), .MUL_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cycles;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act_hi;
    logic [31:0] act_lo;
    logic        act_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_busy;
  } imm_t;

  exp_t q_exp[$];
  imm_t q_imm[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the only process that compares.
  initial begin : monitor
    int unsigned cnt;
    logic        prev;
    exp_t        e;
    imm_t        m;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt  = 0;
        prev = 1'b0;
      end else begin
        if (u_if.busy) cnt++;
        if (prev && !u_if.busy) begin
          if (q_exp.size() == 0) begin
            chk("spurious busy fall", 32'd1, 32'd0);
          end else begin
            e = q_exp.pop_front();
            chk({e.name, " hi"}, u_if.hi, e.hi);
            chk({e.name, " lo"}, u_if.lo, e.lo);
            chk({e.name, " busy cycles"}, cnt, e.cycles);
          end
          cnt = 0;
        end
        prev = u_if.busy;
      end
      while (q_imm.size() > 0) begin
        m = q_imm.pop_front();
        chk({m.name, " hi"}, m.act_hi, m.exp_hi);
        chk({m.name, " lo"}, m.act_lo, m.exp_lo);
        chk({m.name, " busy"}, {31'd0, m.act_busy}, {31'd0, m.exp_busy});
      end
      if (done) begin
        chk("pending expectations", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_res(input string nm, input logic [31:0] hi, input logic [31:0] lo,
                            input int unsigned cycles);
    q_exp.push_back('{nm, hi, lo, cycles});
  endtask

  task automatic snap(input string nm, input logic [31:0] hi, input logic [31:0] lo,
                      input logic busy);
    q_imm.push_back('{nm, u_if.hi, u_if.lo, u_if.busy, hi, lo, busy});
  endtask

  // Called at a negedge; returns at the following negedge with operands scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.a     = a;
    u_if.b     = b;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.a     = $urandom;
    u_if.b     = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!u_if.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) q_imm.push_back('{"busy timeout", u_if.hi, u_if.lo, 1'b1, u_if.hi, u_if.lo, 1'b0});
  endtask

  task automatic flush_at(input int n);
    repeat (n - 1) @(negedge clk);
    u_if.flush = 1'b1;
    @(negedge clk);
    u_if.flush = 1'b0;
  endtask

  initial begin : stimulus
    u_if.start = 1'b0;
    u_if.op    = 3'd0;
    u_if.a     = '0;
    u_if.b     = '0;
    u_if.flush = 1'b0;
    #12 snap("reset", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    expect_res("mult -3*7", 32'hFFFFFFFF, 32'hFFFFFFEB, 4);
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_idle();
    expect_res("multu max*max", 32'hFFFFFFFE, 32'h00000001, 4);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    expect_res("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    expect_res("divu 100/7", 32'd2, 32'd14, 33);
    issue(3'd3, 32'd100, 32'd7);
    wait_idle();
    expect_res("div overflow", 32'h0, 32'h80000000, 33);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    expect_res("divu 5/0", 32'd5, 32'hFFFFFFFF, 33);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle();
    expect_res("div 7/-2", 32'd1, 32'hFFFFFFFD, 33);
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_idle();
    expect_res("div -9/0", 32'hFFFFFFF7, 32'hFFFFFFFF, 33);
    issue(3'd2, 32'hFFFFFFF7, 32'd0);
    wait_idle();

    issue(3'd4, 32'h1234, 32'd0);
    snap("mthi", 32'h1234, 32'hFFFFFFFF, 1'b0);
    issue(3'd5, 32'hABCD, 32'd0);
    snap("mtlo", 32'h1234, 32'hABCD, 1'b0);
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    snap("reserved op6", 32'h1234, 32'hABCD, 1'b0);
    issue(3'd7, 32'hDEAD, 32'hBEEF);
    snap("reserved op7", 32'h1234, 32'hABCD, 1'b0);
    u_if.flush = 1'b1;
    issue(3'd4, 32'h5555, 32'd0);
    u_if.flush = 1'b0;
    snap("flush with mthi", 32'h1234, 32'hABCD, 1'b0);
    u_if.flush = 1'b1;
    @(negedge clk);
    u_if.flush = 1'b0;
    snap("idle flush", 32'h1234, 32'hABCD, 1'b0);

    expect_res("divu ignored start", 32'd1, 32'h14D, 33);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    u_if.start = 1'b1;
    u_if.op    = 3'd0;
    u_if.a     = 32'd2;
    u_if.b     = 32'd3;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_idle();
    @(negedge clk);
    snap("after ignored start", 32'd1, 32'h14D, 1'b0);

    expect_res("divu flushed", 32'd1, 32'h14D, 10);
    issue(3'd3, 32'hFFFF, 32'd2);
    flush_at(10);
    expect_res("mult flushed", 32'd1, 32'h14D, 2);
    issue(3'd0, 32'd3, 32'd3);
    flush_at(2);
    @(negedge clk);
    snap("after flush", 32'd1, 32'h14D, 1'b0);

    issue(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 snap("async reset mid-mult", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    expect_res("multu after reset", 32'h0, 32'h2A, 4);
    issue(3'd1, 32'd6, 32'd7);
    wait_idle();

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/md_hilo_unit.md
Name: md_hilo_unit

Overview:
- Multi-cycle multiply/divide execution unit that owns the HI/LO register pair.
- Carries out the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations that the ID-stage decoder issues, and supplies HI/LO for MFHI/MFLO.
- Sits in the EX stage beside the ALU.
- `busy` feeds the hazard unit, which stalls any later mul/div/MTxx/MFxx instruction while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 4, busy cycles for MULT/MULTU (legal range 1..8).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle issue strobe for op/a/b.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (treated as no-op).
- a  in  WIDTH  rs operand; dividend for DIV/DIVU; write data for MTHI/MTLO.
- b  in  WIDTH  rt operand; divisor for DIV/DIVU.
- flush  in  1  synchronous cancel of the in-flight op (branch/exception squash).
- busy  out  1  high while a MUL or DIV operation is in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous, active-low, and may arrive mid-operation. While asserted: state=IDLE, busy=0, hi=0, lo=0, and the counter and datapath registers are cleared.
- State machine: IDLE, MUL, DIV, FIX.
- Issue: start is sampled only in IDLE with busy=0. Let k be the accepting edge.
- start while busy=1 is ignored. The hazard unit guarantees this never happens; the bench checks that hi/lo are unaffected.
- MTHI/MTLO: at edge k, hi<=a (MTHI) or lo<=a (MTLO). No busy. State stays IDLE.
- Reserved op codes: no effect.
- MULT/MULTU: go to MUL. busy=1 for exactly MUL_CYCLES cycles (edges k..k+MUL_CYCLES-1).
  - At edge k+MUL_CYCLES: {hi,lo} <= 64-bit product, busy<=0, state<=IDLE.
  - MULT treats a and b as two's complement; MULTU treats them as unsigned.
  - Operands are latched at edge k and may change afterwards.
- DIV/DIVU: radix-2 restoring division on magnitudes.
  - DIV latches |a| and |b| plus the quotient and remainder signs. DIVU latches a and b.
  - DIV state: 32 iterations, one quotient bit per cycle, MSB first.
  - FIX state: 1 cycle. Quotient is negated if sign(a) xor sign(b). Remainder takes the sign of a.
  - At the end of FIX: lo<=quotient, hi<=remainder, busy<=0.
  - Total busy = 33 cycles; results are visible after edge k+33.
  - Truncating division: remainder magnitude < |b|, and a = q*b + r holds exactly.
- Divide by zero (b==0 latched at issue): full 33-cycle latency still applies. Result is lo=all ones, hi=a (original value, unsigned or signed alike).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no trap.
- During MUL/DIV/FIX, hi and lo hold their previous values; no partial results are ever visible.
- flush=1 in MUL/DIV/FIX: at the next edge state<=IDLE and busy<=0. hi and lo stay at their pre-issue values.
- flush together with start in IDLE: the start is discarded, including MTHI/MTLO.
- flush in IDLE without start: no effect.
- Back-to-back: a start arriving in the cycle right after busy falls is accepted normally. MFHI/MFLO in that cycle read the new result.

Test Plan:
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=7 -> busy high exactly 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned divide: DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU 5/0 -> after 33 cycles lo=0xFFFFFFFF, hi=5.
- MTHI/MTLO with ignored start: MTHI 0x1234 then MTLO 0xABCD -> hi=0x1234 and lo=0xABCD one edge after each. Then start MULT with busy=1 from a prior DIV -> that start is ignored.
- Flush and reset mid-operation: DIVU issued, flush at busy cycle 10 -> busy=0 next edge, hi/lo unchanged. Then drop rst_n mid-MULT -> busy=0, hi=0, lo=0 immediately, with no clock edge needed.
